// File: rtl/hit_timestamper.sv
// hit_timestamper: stamps rising hit levels with a free-running counter into a FWFT FIFO.
// Optional HIT_DROP_COUNT_EN adds an 8-bit saturating count of dropped events.
module hit_timestamper #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     hit,
  input  logic                     en,
  output logic [CNT_W-1:0]         ts_data,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   ts_level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef HIT_DROP_COUNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic hit_d, evt, pop, full, push, drop;
  assign ts_level = wr_ptr - rd_ptr;
  assign ts_valid = ts_level != '0;
  assign full     = ts_level == (AW+1)'(DEPTH);
  assign ts_data  = ts_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign evt      = hit & ~hit_d & en;
  assign pop      = ts_valid & ts_ready;
  assign push     = evt & (~full | pop);
  assign drop     = evt & full & ~pop;
  // hit_d resets high so a level already present at reset release is not an edge
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      hit_d  <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      hit_d  <= hit;
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      ovf    <= drop | (ovf & ~ovf_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cnt;
  end
`ifdef HIT_DROP_COUNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) drop_cnt <= '0;
    else        drop_cnt <= ovf_clr ? {7'd0, drop} : drop_cnt + {7'd0, drop & ~&drop_cnt};
  end
`endif
endmodule

// File: tb/tb_hit_timestamper.sv
// tb_hit_timestamper: directed and random checks of hit_timestamper against a queue model.
module tb_hit_timestamper;
  logic clk = 1'b0, clr_n = 1'b0, hit = 1'b0, en = 1'b0, ts_ready = 1'b0, ovf_clr = 1'b0;
  logic [15:0] ts_data;
  logic        ts_valid, ovf;
  logic [2:0]  ts_level;
`ifdef HIT_DROP_COUNT_EN
  logic [7:0]  drop_cnt;
`endif
  int checks = 0, errors = 0;
  logic [15:0] m_cnt;
  logic        m_hit_d, m_ovf;
  int          m_drops;
  logic [15:0] q[$];
  logic        stalled = 1'b0;
  logic [15:0] held;
  logic [15:0] exp_ts [5];

  hit_timestamper dut (
    .clk(clk), .clr_n(clr_n), .hit(hit), .en(en),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_level(ts_level), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef HIT_DROP_COUNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, ts_valid}, {31'd0, q.size() != 0});
    chk("level", {29'd0, ts_level}, q.size());
    if (q.size() != 0) chk("data", {16'd0, ts_data}, {16'd0, q[0]});
    if (stalled) chk("stall_hold", {16'd0, ts_data}, {16'd0, held});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`ifdef HIT_DROP_COUNT_EN
    chk("drop_cnt", {24'd0, drop_cnt}, m_drops);
`endif
  endtask

  task automatic step(input logic h, input logic e, input logic r, input logic oc);
    bit ev, pp, fl, dr;
    check_outputs();
    hit = h; en = e; ts_ready = r; ovf_clr = oc;
    stalled = ts_valid && !r;
    held = ts_data;
    @(posedge clk);
    ev = h && !m_hit_d && e;
    pp = q.size() > 0 && r;
    fl = q.size() == 4;
    dr = ev && fl && !pp;
    if (pp) void'(q.pop_front());
    if (ev && !dr) q.push_back(m_cnt);
    m_ovf = dr || (m_ovf && !oc);
    m_drops = oc ? int'(dr) : ((dr && m_drops < 255) ? m_drops + 1 : m_drops);
    m_cnt = m_cnt + 16'd1;
    m_hit_d = h;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic h);
    hit = h; en = 1'b1; ts_ready = 1'b0; ovf_clr = 1'b0;
    clr_n = 1'b0;
    #1;
    q.delete();
    m_cnt = 16'd0; m_hit_d = 1'b1; m_ovf = 1'b0; m_drops = 0; stalled = 1'b0;
    chk("rst_valid", {31'd0, ts_valid}, 32'd0);
    chk("rst_level", {29'd0, ts_level}, 32'd0);
    chk("rst_data", {16'd0, ts_data}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`ifdef HIT_DROP_COUNT_EN
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("first_valid", {31'd0, ts_valid}, 32'd1);
    chk("first_data", {16'd0, ts_data}, 32'd10);
    chk("first_level", {29'd0, ts_level}, 32'd1);
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("long_level_one_entry", {29'd0, ts_level}, 32'd1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("drained", {29'd0, ts_level}, 32'd0);
    do_reset(1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("held_through_reset", {29'd0, ts_level}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_ts[i] = m_cnt;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_level", {29'd0, ts_level}, 32'd4);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_head", {16'd0, ts_data}, {16'd0, exp_ts[0]});
`ifdef HIT_DROP_COUNT_EN
    chk("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd1);
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    exp_ts[4] = m_cnt;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("full_pushpop_level", {29'd0, ts_level}, 32'd4);
    chk("full_pushpop_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      chk("full_pushpop_order", {16'd0, ts_data}, {16'd0, exp_ts[i]});
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("full_pushpop_empty", {31'd0, ts_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 31) == 0));
    while (q.size() != 0) step(1'b0, 1'b1, 1'b1, 1'b0);
    while (m_cnt != 16'hFFFE) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_level", {29'd0, ts_level}, 32'd2);
    chk("wrap_first", {16'd0, ts_data}, 32'hFFFE);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_second", {16'd0, ts_data}, 32'h0001);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hit_timestamper.md
HIT_TIMESTAMPER -- requirements
Module: hit_timestamper

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: coarse counter and timestamp width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: FIFO depth in entries; power of 2, minimum 2.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr_n  input  1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port hit  input  1: registered hit level from the upstream mux/flip-flop stage, synchronous to clk.
REQ-006 The block SHALL have port en  input  1: hit capture enable.
REQ-007 The block SHALL have port ts_data  output  CNT_W: timestamp at the FIFO head.
REQ-008 The block SHALL have port ts_valid  output  1: ts_data is valid.
REQ-009 The block SHALL have port ts_ready  input  1: consumer accepts the head entry.
REQ-010 The block SHALL have port ts_level  output  $clog2(DEPTH)+1: current FIFO occupancy.
REQ-011 The block SHALL have port ovf  output  1: sticky flag; a hit was dropped.
REQ-012 The block SHALL have port ovf_clr  input  1: synchronous clear of ovf.

Function
REQ-013 The coarse counter SHALL increment by 1 every clk cycle, wrap from 2^CNT_W-1 to 0, and never stop (independent of en).
REQ-014 hit_d SHALL be hit delayed by one cycle; an event SHALL be detected at an edge where hit=1, hit_d=0 and en=1.
REQ-015 On an event, the FIFO SHALL store the counter value held just before that edge; each level stays high for one event regardless of its duration.
REQ-016 The FIFO SHALL be first-word fall-through: ts_valid SHALL rise at the same edge that writes into an empty FIFO (1-cycle latency from hit sampled high).
REQ-017 A pop SHALL occur at an edge where ts_valid=1 and ts_ready=1; ts_data SHALL advance to the next entry, or ts_valid SHALL fall if the FIFO becomes empty.
REQ-018 Push into an empty FIFO with ts_ready=1 SHALL NOT bypass: the entry becomes visible first, and is popped at a later handshake.
REQ-019 If the FIFO is full, a push and pop at the same edge SHALL both be accepted, and the level SHALL stay at DEPTH.
REQ-020 If the FIFO is full with no pop, the event SHALL be dropped, FIFO contents SHALL be unchanged, and ovf SHALL be set to 1 at that edge.
REQ-021 ovf_clr=1 SHALL clear ovf; if a drop coincides with ovf_clr, ovf SHALL end at 1 (set wins).
REQ-022 Popping an empty FIFO SHALL be ignored; ts_level SHALL never underflow.
REQ-023 ts_data SHALL hold its value while ts_valid=1 and ts_ready=0.
REQ-024 Toggling en mid-level SHALL NOT create an event; an event needs en=1 at the rising-level edge only.

Reset
REQ-025 clr_n=0 SHALL immediately set counter=0, FIFO empty, ts_level=0, ts_valid=0, ts_data=0, ovf=0 and hit_d=1.
REQ-026 Because hit_d resets to 1, a hit held high through reset release SHALL NOT generate an event.
REQ-027 Reset asserted mid-operation SHALL discard all stored timestamps, with no partial pop.
REQ-028 Counting SHALL restart from 0 at the first edge after clr_n rises.

Configuration
REQ-029 With macro HIT_DROP_COUNT_EN defined, the block SHALL add output drop_cnt (8 bits), which counts dropped events, saturates at 255, is cleared by ovf_clr or reset, and increments when a drop coincides with ovf_clr, ending at 1.
REQ-030 Without HIT_DROP_COUNT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset release, en=1, hit rises at cycle 10 with ts_ready=0 -> ts_valid=1 one edge later, ts_data=10, ts_level=1.
REQ-032 hit held high for 20 cycles -> exactly one entry is written; hit held high across reset release -> no entry is written.
REQ-033 Counter near 0xFFFF: hits at counter values 0xFFFE and 0x0001 -> ts_data=0xFFFE, then 0x0001, in order.
REQ-034 ts_ready=0 with 5 hit pulses (DEPTH=4) -> ts_level=4, ovf=1, the first 4 timestamps are retained, drop_cnt=1 when enabled; ovf_clr -> ovf=0.
REQ-035 FIFO full, then a hit with ts_ready=1 at the same edge -> the head is popped, the new entry is appended, ts_level=4 and ovf stays 0.
REQ-036 Random hits, en and ts_ready for 10k cycles -> a scoreboard shows no loss except counted drops, order is preserved, and data is stable while stalled.
